exu_rcv_buf: RTL
================

// Module: exu_rcv_buf
// PURPOSE
//  Receiving end of the EXU valid/ready result interface. Drives EXU's i_ready and
//  captures its ALU result/flags and jump request when EXU asserts o_valid.
//  Two-entry skid buffer: full throughput with registered upstream ready; presents
//  the buffered result to the next stage (LSU/WBU) over its own valid/ready pair.
//  Sits between EXU and LSU; i_flush discards in-flight results on a redirect.
// PARAMETERS
//  DATA_WIDTH  32  ALU result width (`DATA_WIDTH)
//  ADDR_WIDTH  32  jump PC width (`ADDR_WIDTH)
// PORTS
//  i_clk         in   1           clock, all state on rising edge
//  i_rst         in   1           synchronous reset, active-high
//  i_flush       in   1           sync flush: drop all buffered entries
//  i_valid       in   1           upstream (EXU o_valid) result valid
//  o_ready       out  1           to EXU i_ready; buffer can accept
//  i_alu_res     in   DATA_WIDTH  ALU result
//  i_alu_zero    in   1           ALU zero flag
//  i_alu_over    in   1           ALU overflow flag
//  i_alu_nega    in   1           ALU negative flag
//  i_jmp_en      in   1           jump request
//  i_jmp_pc      in   ADDR_WIDTH  jump target
//  o_valid       out  1           downstream entry valid
//  i_ready       in   1           downstream accepts
//  o_alu_res     out  DATA_WIDTH  head-entry result
//  o_alu_zero    out  1           head-entry zero flag
//  o_alu_over    out  1           head-entry overflow flag
//  o_alu_nega    out  1           head-entry negative flag
//  o_jmp_en      out  1           head-entry jump request
//  o_jmp_pc      out  ADDR_WIDTH  head-entry jump target
//  o_occ         out  2           occupancy 0..2
// BEHAVIOUR
//  - in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
//  - State: EMPTY (0 entries), HALF (main reg), FULL (main + skid reg).
//    o_valid = (state != EMPTY); o_ready = (state != FULL) and not in reset;
//    o_occ = 0/1/2.
//  - EMPTY: in_fire -> HALF, main <= input.
//  - HALF: in_fire & !out_fire -> FULL, skid <= input;
//          out_fire & !in_fire -> EMPTY;
//          in_fire & out_fire -> HALF, main <= input.
//  - FULL: o_ready=0 so no in_fire; out_fire -> HALF, main <= skid.
//  - Latency: in_fire in cycle N -> o_valid with that data in N+1. Throughput 1/cycle.
//  - Order strictly FIFO; no entry dropped or duplicated except on flush/reset.
//  - All o_* data/flag outputs are driven from main reg and forced to 0 while o_valid=0.
//  - i_flush: next state EMPTY, main/skid cleared to 0. Any in_fire or out_fire in the
//    flush cycle is discarded and not counted. Flush beats both fire events.
//  - i_rst: state EMPTY, all regs 0. Outputs after the reset edge: o_valid=0, o_ready=0
//    while i_rst=1, o_occ=0, all data 0. o_ready=1 in the first cycle after i_rst
//    deasserts. Reset mid-transfer drops everything. Reset beats flush.
//  - Upstream contract (checked by assertion): i_valid held with stable data until
//    in_fire. Downstream may toggle i_ready freely.
// TESTING
//  - Reset: i_rst=1 for 2 cycles with i_valid=1 -> o_valid=0, o_ready=0, o_occ=0;
//    release -> o_ready=1 next cycle.
//  - Streaming: i_ready=1, push res 0x10,0x11,0x12 on back-to-back cycles -> same
//    values out in cycles +1..+3, o_occ stays 1, o_ready stays 1.
//  - Backpressure: i_ready=0, push 0xA then 0xB -> o_occ=2, o_ready=0, o_alu_res=0xA;
//    i_ready=1 -> 0xA then 0xB out, o_ready=1 after the first pop.
//  - Flush in FULL: entries 0x1,0x2 held, i_flush=1 with i_valid=1 (0x3) ->
//    next cycle o_valid=0, o_occ=0, 0x3 never appears downstream.
//  - Jump path: push jmp_en=1, jmp_pc=0x8000_0040, zero=1 -> o_jmp_en=1,
//    o_jmp_pc=0x8000_0040, o_alu_zero=1 next cycle; all outputs 0 once drained.
//  - Random valid/ready for 10k cycles vs scoreboard -> in-order, lossless, o_occ<=2.

Source files
------------

// File: rtl/exu_rcv_buf.sv
// ----------------------------------------------------------------------------
// exu_rcv_buf
//
// This block is the receiving end of the EXU result interface. It sits
// between EXU and the next stage (LSU/WBU).
//
// Upstream valid/ready (EXU side):
//   i_valid, o_ready, i_alu_res, i_alu_zero, i_alu_over, i_alu_nega,
//   i_jmp_en, i_jmp_pc
//
// Downstream valid/ready (LSU/WBU side):
//   o_valid, i_ready, o_alu_res, o_alu_zero, o_alu_over, o_alu_nega,
//   o_jmp_en, o_jmp_pc
//
// Control and status:
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset
//   i_flush  synchronous flush; drops every buffered entry
//   o_occ    number of buffered entries (0..2)
//
// Buffering scheme:
//   The buffer has two entries, which gives a skid-buffer arrangement.
//   The main register always holds the head entry.
//   The skid register holds the second entry, which can only be captured
//   while the head is stalled.
//
//   o_ready depends only on registered state (and on reset). Upstream
//   therefore never sees a combinational path from i_ready, and the
//   buffer still sustains one transfer per cycle.
// ----------------------------------------------------------------------------
module exu_rcv_buf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,

    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_alu_res,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_over,
    input  logic                  i_alu_nega,
    input  logic                  i_jmp_en,
    input  logic [ADDR_WIDTH-1:0] i_jmp_pc,

    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_alu_res,
    output logic                  o_alu_zero,
    output logic                  o_alu_over,
    output logic                  o_alu_nega,
    output logic                  o_jmp_en,
    output logic [ADDR_WIDTH-1:0] o_jmp_pc,

    output logic [1:0]            o_occ
);

    // One buffered result, carried as a single word.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu_res;
        logic                  alu_zero;
        logic                  alu_over;
        logic                  alu_nega;
        logic                  jmp_en;
        logic [ADDR_WIDTH-1:0] jmp_pc;
    } entry_t;

    // State encoding equals occupancy.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StHalf  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t main_q,  main_d;
    entry_t skid_q,  skid_d;

    entry_t in_entry;
    logic   in_fire;
    logic   out_fire;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    always_comb begin
        in_entry.alu_res  = i_alu_res;
        in_entry.alu_zero = i_alu_zero;
        in_entry.alu_over = i_alu_over;
        in_entry.alu_nega = i_alu_nega;
        in_entry.jmp_en   = i_jmp_en;
        in_entry.jmp_pc   = i_jmp_pc;
    end

    assign o_valid  = (state_q != StEmpty);
    // Ready is held low during reset so that EXU cannot hand over a result
    // that the reset would then silently drop.
    assign o_ready  = (state_q != StFull) && !i_rst;
    assign in_fire  = i_valid && o_ready;
    assign out_fire = o_valid && i_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (i_flush) begin
            // A flush overrides both fire events in the same cycle.
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StHalf;
                        main_d  = in_entry;
                    end
                end
                StHalf: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        state_d = StFull;
                        skid_d  = in_entry;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                        main_d  = '0;
                    end
                end
                StFull: begin
                    // o_ready is low here, so only the pop can happen.
                    if (out_fire) begin
                        state_d = StHalf;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the head entry, forced to zero while nothing is valid
    // ------------------------------------------------------------------
    always_comb begin
        o_alu_res  = '0;
        o_alu_zero = 1'b0;
        o_alu_over = 1'b0;
        o_alu_nega = 1'b0;
        o_jmp_en   = 1'b0;
        o_jmp_pc   = '0;
        if (o_valid) begin
            o_alu_res  = main_q.alu_res;
            o_alu_zero = main_q.alu_zero;
            o_alu_over = main_q.alu_over;
            o_alu_nega = main_q.alu_nega;
            o_jmp_en   = main_q.jmp_en;
            o_jmp_pc   = main_q.jmp_pc;
        end
    end

    always_comb begin
        unique case (state_q)
            StEmpty: o_occ = 2'd0;
            StHalf:  o_occ = 2'd1;
            StFull:  o_occ = 2'd2;
            default: o_occ = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Upstream contract
    // ------------------------------------------------------------------
    // A stalled offer must be held, with stable data, until it is taken.
    // A flush cancels the offer as well, because the redirect also kills
    // EXU's in-flight result.
    a_upstream_hold : assert property (
        @(posedge i_clk) disable iff (i_rst || i_flush)
        (i_valid && !o_ready) |=> (i_valid && $stable(in_entry))
    ) else $error("exu_rcv_buf: upstream dropped or changed a stalled result");

endmodule
